// File: rtl/sw_pkg.sv
// Shared constants and traceback encodings for the Smith-Waterman processing element.
package sw_pkg;

  typedef enum logic [1:0] {
    TB_ZERO = 2'b00,
    TB_DIAG = 2'b01,
    TB_UP   = 2'b10,
    TB_LEFT = 2'b11
  } tb_e;

  function automatic int neg_inf(input int w);
    return -(2 ** (w - 1));
  endfunction

  function automatic int pos_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sw_sat_addmax.sv
// Two saturating signed adds (a0+b0, a1+b1) and the max of the two results.
module sw_sat_addmax
  import sw_pkg::*;
#(
  parameter int SCORE_W = 12
) (
  input  logic signed [SCORE_W-1:0] a0,
  input  logic signed [SCORE_W:0]   b0,
  input  logic signed [SCORE_W-1:0] a1,
  input  logic signed [SCORE_W:0]   b1,
  output logic signed [SCORE_W-1:0] sum0,
  output logic signed [SCORE_W-1:0] mx
);

  localparam int XW = SCORE_W + 2;
  localparam logic signed [XW-1:0] LO = XW'(neg_inf(SCORE_W));
  localparam logic signed [XW-1:0] HI = XW'(pos_max(SCORE_W));

  logic signed [XW-1:0]      raw0;
  logic signed [XW-1:0]      raw1;
  logic signed [SCORE_W-1:0] sum1;

  // b is one bit wider so a negated unsigned penalty always fits
  function automatic logic signed [SCORE_W-1:0] clip(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] y;
    y = x;
    if (x > HI) y = HI;
    else if (x < LO) y = LO;
    return y[SCORE_W-1:0];
  endfunction

  assign raw0 = XW'(a0) + XW'(b0);
  assign raw1 = XW'(a1) + XW'(b1);
  assign sum0 = clip(raw0);
  assign sum1 = clip(raw1);
  assign mx   = (sum0 >= sum1) ? sum0 : sum1;

endmodule

// File: rtl/sw_pe_affine.sv
// Affine-gap Smith-Waterman / Needleman-Wunsch processing element; one DP cell per valid cycle.
module sw_pe_affine
  import sw_pkg::*;
#(
  parameter int SCORE_W = 12,
  parameter int SYM_W   = 2,
  parameter int COL_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_local,
  input  logic signed [SCORE_W-1:0] cfg_match,
  input  logic signed [SCORE_W-1:0] cfg_mismatch,
  input  logic        [SCORE_W-1:0] cfg_gap_open,
  input  logic        [SCORE_W-1:0] cfg_gap_ext,
  input  logic                      ld_s_in,
  input  logic        [SYM_W-1:0]   s_in,
  input  logic                      vld_in,
  input  logic        [SYM_W-1:0]   t_in,
  input  logic signed [SCORE_W-1:0] v_in,
  input  logic signed [SCORE_W-1:0] f_in,
  input  logic signed [SCORE_W-1:0] max_in,
  input  logic        [COL_W-1:0]   maxcol_in,
  output logic                      ld_s_out,
  output logic                      vld_out,
  output logic        [SYM_W-1:0]   t_out,
  output logic signed [SCORE_W-1:0] v_out,
  output logic signed [SCORE_W-1:0] f_out,
  output logic signed [SCORE_W-1:0] max_out,
  output logic        [COL_W-1:0]   maxcol_out,
  output logic        [1:0]         tb_out
);

  localparam logic signed [SCORE_W-1:0] NEG_INF = SCORE_W'(neg_inf(SCORE_W));

  logic        [SYM_W-1:0]   s_reg, s_cur;
  logic        [COL_W-1:0]   col_cnt, col_cur, col_inc;
  logic signed [SCORE_W-1:0] best_reg, best_cur, best_new;
  logic        [COL_W-1:0]   best_col, bcol_cur, bcol_new;
  logic signed [SCORE_W-1:0] v_diag, vdiag_cur;
  logic signed [SCORE_W-1:0] e_reg, e_prev;
  logic signed [SCORE_W-1:0] sub, e_new, f_new, ef_max, d_val, h_raw, h_val;
  logic signed [SCORE_W-1:0] e_sum_unused, f_sum_unused;
  logic signed [SCORE_W:0]   neg_open, neg_ext, sub_w;
  logic                      clamp;
  logic        [1:0]         tb_val;
  logic signed [SCORE_W-1:0] max_sel;
  logic        [COL_W-1:0]   maxcol_sel;

  assign s_cur     = ld_s_in ? s_in : s_reg;
  assign col_cur   = ld_s_in ? '0 : col_cnt;
  assign best_cur  = ld_s_in ? '0 : best_reg;
  assign bcol_cur  = ld_s_in ? '0 : best_col;
  assign e_prev    = ld_s_in ? NEG_INF : e_reg;
  // a fresh pass starts from a zero corner in local mode, -inf in global mode
  assign vdiag_cur = ld_s_in ? (cfg_local ? '0 : NEG_INF) : v_diag;

  assign neg_open = -$signed({1'b0, cfg_gap_open});
  assign neg_ext  = -$signed({1'b0, cfg_gap_ext});
  assign sub      = (s_cur == t_in) ? cfg_match : cfg_mismatch;
  assign sub_w    = (SCORE_W+1)'(sub);

  sw_sat_addmax #(.SCORE_W(SCORE_W)) u_e (
    .a0(e_prev), .b0(neg_ext), .a1(v_out), .b1(neg_open), .sum0(e_sum_unused), .mx(e_new)
  );

  sw_sat_addmax #(.SCORE_W(SCORE_W)) u_f (
    .a0(f_in), .b0(neg_ext), .a1(v_in), .b1(neg_open), .sum0(f_sum_unused), .mx(f_new)
  );

  assign ef_max = (e_new >= f_new) ? e_new : f_new;

  sw_sat_addmax #(.SCORE_W(SCORE_W)) u_d (
    .a0(vdiag_cur), .b0(sub_w), .a1(ef_max), .b1('0), .sum0(d_val), .mx(h_raw)
  );

  assign clamp = cfg_local && h_raw[SCORE_W-1];
  assign h_val = clamp ? '0 : h_raw;

  always_comb begin
    tb_val = TB_LEFT;
    if (clamp) tb_val = TB_ZERO;
    else if (d_val == h_raw) tb_val = TB_DIAG;
    else if (f_new == h_raw) tb_val = TB_UP;
  end

  assign col_inc  = (col_cur == '1) ? col_cur : col_cur + 1'b1;
  assign best_new = (h_val > best_cur) ? h_val : best_cur;
  assign bcol_new = (h_val > best_cur) ? col_cur : bcol_cur;

  assign max_sel    = (best_new > max_in) ? best_new : max_in;
  assign maxcol_sel = (best_new > max_in) ? bcol_new : maxcol_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg      <= '0;
      col_cnt    <= '0;
      best_reg   <= '0;
      best_col   <= '0;
      v_diag     <= '0;
      e_reg      <= NEG_INF;
      ld_s_out   <= 1'b0;
      vld_out    <= 1'b0;
      t_out      <= '0;
      v_out      <= '0;
      f_out      <= '0;
      max_out    <= '0;
      maxcol_out <= '0;
      tb_out     <= TB_ZERO;
    end else begin
      s_reg    <= s_cur;
      ld_s_out <= ld_s_in;
      vld_out  <= vld_in;
      t_out    <= t_in;
      if (vld_in) begin
        v_out      <= h_val;
        f_out      <= f_new;
        e_reg      <= e_new;
        v_diag     <= v_in;
        tb_out     <= tb_val;
        col_cnt    <= col_inc;
        best_reg   <= best_new;
        best_col   <= bcol_new;
        max_out    <= max_sel;
        maxcol_out <= maxcol_sel;
      end else begin
        v_out      <= '0;
        f_out      <= NEG_INF;
        e_reg      <= NEG_INF;
        v_diag     <= '0;
        tb_out     <= TB_ZERO;
        col_cnt    <= col_cur;
        best_reg   <= best_cur;
        best_col   <= bcol_cur;
        max_out    <= max_in;
        maxcol_out <= maxcol_in;
      end
    end
  end

endmodule
